// File: rtl/instruction_fetch_controller.sv
// -----------------------------------------------------------------------------
// instruction_fetch_controller
//
// Fetch-side initiator for the instruction memory. Owns the program counter,
// presents it as the memory byte address and registers the combinationally
// returned instruction into the IF/ID pipeline register. Handles stall, flush,
// branch redirect and (optionally) an address-fault halt.
//
// Optional feature macro: IFETCH_ALIGN_CHECK_EN
//   defined   : a misaligned or out-of-range next PC raises a sticky Fault and
//               halts fetch; the faulting PC is never loaded.
//   undefined : no fault detection, Fault stays 0, branch targets are forced
//               word-aligned and the PC may run past the memory (aliasing).
//
// Parameters
//   RESET_PC    PC loaded on reset (word-aligned)
//   IMEM_WORDS  instruction memory depth in words
//
// Ports
//   Clk_i              rising-edge clock
//   Reset_i            synchronous active-high reset
//   Stall_i            hold PC and IF/ID
//   Flush_i            invalidate IF/ID on this edge
//   BranchTaken_i      redirect PC to BranchTarget_i on this edge
//   BranchTarget_i     redirect byte address
//   MemAddress_o       byte address to instruction memory (= PC)
//   MemInstruction_i   combinational read data for MemAddress_o
//   PC_o               current fetch address
//   IfIdInstruction_o  registered instruction
//   IfIdPCPlus4_o      registered PC+4 of that instruction
//   IfIdValid_o        IF/ID holds a live instruction
//   FetchCount_o       count of valid IF/ID loads, saturating
//   Fault_o            sticky address fault
// -----------------------------------------------------------------------------
module instruction_fetch_controller #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 128
) (
    input  logic        Clk_i,
    input  logic        Reset_i,
    input  logic        Stall_i,
    input  logic        Flush_i,
    input  logic        BranchTaken_i,
    input  logic [31:0] BranchTarget_i,
    output logic [31:0] MemAddress_o,
    input  logic [31:0] MemInstruction_i,
    output logic [31:0] PC_o,
    output logic [31:0] IfIdInstruction_o,
    output logic [31:0] IfIdPCPlus4_o,
    output logic        IfIdValid_o,
    output logic [31:0] FetchCount_o,
    output logic        Fault_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic [31:0] cnt_q, cnt_d;
    logic        fault_q, fault_d;

    logic [31:0] pc_plus4;
    logic [31:0] tgt;
    logic        fault_hit;

    assign pc_plus4 = pc_q + 32'd4;

`ifdef IFETCH_ALIGN_CHECK_EN
    localparam logic [31:0] LIMIT = 32'(4 * IMEM_WORDS);
    logic [31:0] pc_next;

    assign tgt = BranchTarget_i;
    // The address this edge would load; a stall reloads the current
    // (already legal) PC and so can never fault.
    assign pc_next   = BranchTaken_i ? tgt : (Stall_i ? pc_q : pc_plus4);
    assign fault_hit = (pc_next[1:0] != 2'b00) || (pc_next >= LIMIT);
`else
    logic tgt_lsb_unused;

    // Low target bits are discarded so the PC always stays word-aligned.
    assign tgt            = {BranchTarget_i[31:2], 2'b00};
    assign tgt_lsb_unused = ^BranchTarget_i[1:0];
    assign fault_hit      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        unique case (state_q)
            BOOT: begin
                // One dead cycle after reset: nothing is loaded.
                state_d = RUN;
                valid_d = 1'b0;
            end
            RUN: begin
                if (fault_hit) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                    valid_d = 1'b0;
                end else if (BranchTaken_i) begin
                    // Instruction fetched this cycle is on the wrong path.
                    pc_d    = tgt;
                    valid_d = 1'b0;
                end else if (Stall_i) begin
                    if (Flush_i) valid_d = 1'b0;
                end else begin
                    instr_d = MemInstruction_i;
                    pcp4_d  = pc_plus4;
                    valid_d = !Flush_i;
                    pc_d    = pc_plus4;
                    if (!Flush_i && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
                end
            end
            HALT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            pcp4_q  <= 32'd0;
            valid_q <= 1'b0;
            cnt_q   <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign MemAddress_o      = pc_q;
    assign PC_o              = pc_q;
    assign IfIdInstruction_o = instr_q;
    assign IfIdPCPlus4_o     = pcp4_q;
    assign IfIdValid_o       = valid_q;
    assign FetchCount_o      = cnt_q;
    assign Fault_o           = fault_q;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_controller
//
// Directed walk through reset/boot, sequential fetch, stall, branch, flush,
// fault (when IFETCH_ALIGN_CHECK_EN is defined) and end-of-range behaviour,
// followed by randomized traffic. Every cycle all outputs are compared with a
// behavioural reference model; directed steps add hand-computed constants.
// Bench memory: word i holds i*3, indexed by address bits [8:2].
// -----------------------------------------------------------------------------
module tb_instruction_fetch_controller;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned IMEM_WORDS = 128;

    logic        clk = 1'b0;
    logic        Reset, Stall, Flush, BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] MemAddress, MemInstruction, PC;
    logic [31:0] IfIdInstruction, IfIdPCPlus4, FetchCount;
    logic        IfIdValid, Fault;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    logic [31:0] m_pc, m_ins, m_p4, m_cnt;
    bit          m_vld, m_flt, m_boot, m_halt;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] idx;
        idx = {25'd0, addr[8:2]};
        return idx * 32'd3;
    endfunction

    assign MemInstruction = mem_word(MemAddress);

    instruction_fetch_controller #(
        .RESET_PC  (RESET_PC),
        .IMEM_WORDS(IMEM_WORDS)
    ) dut (
        .Clk_i            (clk),
        .Reset_i          (Reset),
        .Stall_i          (Stall),
        .Flush_i          (Flush),
        .BranchTaken_i    (BranchTaken),
        .BranchTarget_i   (BranchTarget),
        .MemAddress_o     (MemAddress),
        .MemInstruction_i (MemInstruction),
        .PC_o             (PC),
        .IfIdInstruction_o(IfIdInstruction),
        .IfIdPCPlus4_o    (IfIdPCPlus4),
        .IfIdValid_o      (IfIdValid),
        .FetchCount_o     (FetchCount),
        .Fault_o          (Fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("pc",      PC,                 m_pc);
        chk("memaddr", MemAddress,         m_pc);
        chk("ins",     IfIdInstruction,    m_ins);
        chk("pcp4",    IfIdPCPlus4,        m_p4);
        chk("valid",   {31'd0, IfIdValid}, {31'd0, m_vld});
        chk("count",   FetchCount,         m_cnt);
        chk("fault",   {31'd0, Fault},     {31'd0, m_flt});
    endtask

    // Drive one cycle of inputs, advance the model by the fetch rules,
    // then compare after the edge.
    task automatic step(input bit rst, input bit br, input bit st, input bit fl,
                        input logic [31:0] tgt);
        logic [31:0] nxt;
        bit          bad;
        @(negedge clk);
        Reset = rst; BranchTaken = br; Stall = st; Flush = fl; BranchTarget = tgt;
        if (rst) begin
            m_pc = RESET_PC; m_ins = 0; m_p4 = 0; m_vld = 0; m_cnt = 0;
            m_flt = 0; m_boot = 1; m_halt = 0;
        end else if (m_boot) begin
            m_boot = 0; m_vld = 0;
        end else if (m_halt) begin
            m_vld = 0;
        end else begin
            nxt = br ? tgt : (st ? m_pc : m_pc + 32'd4);
`ifdef IFETCH_ALIGN_CHECK_EN
            bad = (nxt % 4 != 0) || (nxt >= 4 * IMEM_WORDS);
`else
            bad = 0;
`endif
            if (bad) begin
                m_halt = 1; m_flt = 1; m_vld = 0;
            end else if (br) begin
                m_pc = nxt - (nxt % 4); m_vld = 0;
            end else if (st) begin
                if (fl) m_vld = 0;
            end else begin
                m_ins = mem_word(m_pc);
                m_p4  = m_pc + 32'd4;
                m_vld = !fl;
                if (!fl && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                m_pc  = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        chk_model();
    endtask

    initial begin
        Reset = 1; Stall = 0; Flush = 0; BranchTaken = 0; BranchTarget = 0;

        // reset state
        step(1, 0, 0, 0, 0);
        chk("rst_pc", PC, RESET_PC);
        chk("rst_valid", {31'd0, IfIdValid}, 32'd0);
        chk("rst_count", FetchCount, 32'd0);
        chk("rst_ins", IfIdInstruction, 32'd0);

        // BOOT: one cycle, nothing loaded
        step(0, 0, 0, 0, 0);
        chk("boot_valid", {31'd0, IfIdValid}, 32'd0);
        chk("boot_pc", PC, 32'h0);

        // sequential fetch
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0);
            chk("seq_ins", IfIdInstruction, 32'(i * 3));
            chk("seq_pcp4", IfIdPCPlus4, 32'(4 * (i + 1)));
        end
        chk("seq_count", FetchCount, 32'd4);
        chk("seq_pc", PC, 32'h10);

        // stall three cycles at 0x10
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0);
            chk("stall_pc", PC, 32'h10);
            chk("stall_ins", IfIdInstruction, 32'd9);
        end
        step(0, 0, 0, 0, 0);
        chk("unstall_ins", IfIdInstruction, 32'd12);

        // get to 0x08, then branch to 0x40
        step(0, 1, 0, 0, 32'h08);
        chk("br8_pc", PC, 32'h08);
        step(0, 1, 0, 0, 32'h40);
        chk("br_valid", {31'd0, IfIdValid}, 32'd0);
        chk("br_pc", PC, 32'h40);
        step(0, 0, 0, 0, 0);
        chk("br_ins", IfIdInstruction, 32'd48);
        chk("br_pcp4", IfIdPCPlus4, 32'h44);
        chk("br_valid1", {31'd0, IfIdValid}, 32'd1);

        // stall + flush together
        step(0, 0, 1, 1, 0);
        chk("sf_valid", {31'd0, IfIdValid}, 32'd0);
        chk("sf_pc", PC, 32'h44);

        // reset during a branch cycle
        step(1, 1, 0, 0, 32'h80);
        chk("rstbr_pc", PC, RESET_PC);
        step(0, 0, 0, 0, 0);

        // misaligned branch target
        step(0, 1, 0, 0, 32'h42);
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("mis_fault", {31'd0, Fault}, 32'd1);
        chk("mis_pc", PC, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step(0, i[0], 0, 0, 32'h40);
            chk("halt_fault", {31'd0, Fault}, 32'd1);
            chk("halt_pc", PC, 32'h0);
        end
`else
        chk("mis_pc", PC, 32'h40);
`endif
        step(1, 0, 0, 0, 0);
        chk("rst2_fault", {31'd0, Fault}, 32'd0);
        step(0, 0, 0, 0, 0);

        // end of range
        step(0, 1, 0, 0, 32'h1F8);
        chk("end_pc0", PC, 32'h1F8);
        step(0, 0, 0, 0, 0);
        chk("end_pc1", PC, 32'h1FC);
        chk("end_ins1", IfIdInstruction, 32'd378);
        step(0, 0, 0, 0, 0);
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("end_fault", {31'd0, Fault}, 32'd1);
        chk("end_pc2", PC, 32'h1FC);
`else
        chk("end_pc2", PC, 32'h200);
        chk("end_ins2", IfIdInstruction, 32'd381);
`endif
        step(0, 0, 0, 0, 0);
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("end_fault2", {31'd0, Fault}, 32'd1);
`else
        chk("alias_ins", IfIdInstruction, 32'd0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            bit r, b, s, f;
            r = ($urandom_range(0, 39) == 0);
            b = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) != 0) t = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
            else t = $urandom;
            step(r, b, s, f, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
